// File: rtl/seven_reg_writeback_demux.sv
// Write-back steering for the seven datapath holding registers a..g.
// Writes are queued behind a valid/ready port and committed one per cycle.
module seven_reg_writeback_demux #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       wr_sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [6:0]       upd,
  output logic             busy,
  output logic             err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qdata_q [DEPTH];
  logic [WIDTH-1:0] qdata_d [DEPTH];
  logic [2:0]       qsel_q  [DEPTH];
  logic [2:0]       qsel_d  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] reg_q [7];
  logic [WIDTH-1:0] reg_d [7];
  logic [6:0]       upd_q, upd_d;
  logic             err_q, err_d;

  logic             accept;
  logic             pop;
  logic [WIDTH-1:0] head_data;
  logic [2:0]       head_sel;

  assign wr_ready  = (count_q != CNT_FULL);
  assign accept    = wr_valid & wr_ready;
  assign pop       = (state_q == DRAIN);
  assign head_data = qdata_q[rd_ptr_q];
  assign head_sel  = qsel_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      qdata_d[i] = qdata_q[i];
      qsel_d[i]  = qsel_q[i];
    end

    if (accept) begin
      qdata_d[wr_ptr_q] = wr_data;
      qsel_d[wr_ptr_q]  = wr_sel;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      IDLE:  if (accept) state_d = DRAIN;
      DRAIN: if ((count_q == CNT_ONE) && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit of the popped head; sel 111 only raises the sticky error.
  always_comb begin
    upd_d = '0;
    err_d = err_q;
    for (int unsigned i = 0; i < 7; i++) begin
      reg_d[i] = reg_q[i];
      if (pop && (head_sel == 3'(i))) begin
        reg_d[i] = head_data;
        upd_d[i] = 1'b1;
      end
    end
    if (err_clr) err_d = 1'b0;
    if (pop && (head_sel == 3'b111)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      upd_q    <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        qdata_q[i] <= '0;
        qsel_q[i]  <= '0;
      end
      for (int unsigned i = 0; i < 7; i++) reg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        qdata_q[i] <= qdata_d[i];
        qsel_q[i]  <= qsel_d[i];
      end
      for (int unsigned i = 0; i < 7; i++) reg_q[i] <= reg_d[i];
    end
  end

  assign a    = reg_q[0];
  assign b    = reg_q[1];
  assign c    = reg_q[2];
  assign d    = reg_q[3];
  assign e    = reg_q[4];
  assign f    = reg_q[5];
  assign g    = reg_q[6];
  assign upd  = upd_q;
  assign busy = (state_q == DRAIN);
  assign err  = err_q;

endmodule

// File: tb/tb_seven_reg_writeback_demux.sv
// Scoreboard bench for seven_reg_writeback_demux: accepted writes are queued with
// their expected commit edge and compared against a..g/upd/err/busy every cycle.
module tb_seven_reg_writeback_demux;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       wr_sel;
  logic             err_clr;
  logic [WIDTH-1:0] a, b, c, d, e, f, g;
  logic [6:0]       upd;
  logic             busy;
  logic             err;

  seven_reg_writeback_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sel(wr_sel),
    .err_clr(err_clr),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .upd(upd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       sel;
    logic [WIDTH-1:0] data;
    int unsigned      cyc;
  } ent_t;

  ent_t             sbq[$];
  logic [WIDTH-1:0] m_reg [7];
  logic [6:0]       m_upd;
  logic             m_err;
  int unsigned      cyc;
  int unsigned      last_commit;
  int               checks;
  int               failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] m_regs();
    return {m_reg[6], m_reg[5], m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  // One clock: drive inputs, predict, advance, then compare on the falling edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [WIDTH-1:0] dat,
                      input logic clr, output logic acc);
    logic exp_ready;
    ent_t ent;
    wr_valid = v; wr_sel = s; wr_data = dat; err_clr = clr;
    #1;
    exp_ready = (sbq.size() < DEPTH);
    check("wr_ready", 64'(wr_ready), 64'(exp_ready));
    acc = v && exp_ready;
    if (acc) begin
      ent.sel  = s;
      ent.data = dat;
      ent.cyc  = (last_commit + 1 > cyc + 2) ? last_commit + 1 : cyc + 2;
      last_commit = ent.cyc;
      sbq.push_back(ent);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    m_upd = '0;
    if (clr) m_err = 1'b0;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      ent = sbq.pop_front();
      if (ent.sel == 3'b111) m_err = 1'b1;
      else begin
        m_reg[ent.sel] = ent.data;
        m_upd[ent.sel] = 1'b1;
      end
    end
    check("upd",  64'(upd), 64'(m_upd));
    check("regs", 64'({g, f, e, d, c, b, a}), 64'(m_regs()));
    check("err",  64'(err), 64'(m_err));
    check("busy", 64'(busy), 64'(sbq.size() != 0));
    wr_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic send(input logic [2:0] s, input logic [WIDTH-1:0] dat, input logic clr);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) step(1'b1, s, dat, clr, acc);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, '0, 1'b0, acc);
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int i = 0; i < 7; i++) m_reg[i] = '0;
    m_upd = '0;
    m_err = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; last_commit = 0;
    wr_valid = 1'b0; wr_data = '0; wr_sel = '0; err_clr = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_regs",  64'({g, f, e, d, c, b, a}), 64'd0);
    check("rst_ready", 64'(wr_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // single write to d
    send(3'b011, 8'hA5, 1'b0);
    idle(2);

    // back-to-back fill a, b, c
    send(3'b000, 8'h11, 1'b0);
    send(3'b001, 8'h22, 1'b0);
    send(3'b010, 8'h33, 1'b0);
    idle(3);

    // held-valid burst across all registers, no data lost
    for (int i = 0; i < 7; i++) send(3'(i), 8'(8'h40 + i), 1'b0);
    idle(3);

    // illegal destination, then clear
    send(3'b111, 8'hFF, 1'b0);
    idle(3);
    begin
      logic acc;
      step(1'b0, 3'b000, '0, 1'b1, acc);
    end
    idle(1);
    // clear coinciding with an illegal commit: set wins
    send(3'b111, 8'hFF, 1'b0);
    begin
      logic acc;
      step(1'b0, 3'b000, '0, 1'b1, acc);
    end
    idle(2);

    // same target twice
    send(3'b110, 8'h01, 1'b0);
    send(3'b110, 8'h02, 1'b0);
    idle(3);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic acc;
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 3) == 0), acc);
    end
    idle(3);

    // asynchronous reset mid-drain
    send(3'b000, 8'h99, 1'b0);
    send(3'b111, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_regs",  64'({g, f, e, d, c, b, a}), 64'd0);
    check("mid_rst_upd",   64'(upd), 64'd0);
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_err",   64'(err), 64'd0);
    check("mid_rst_ready", 64'(wr_ready), 64'd1);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b101, 8'h5A, 1'b0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
